// File: rtl/segre_rf_ckpt_if.sv
// Bus bundle for the checkpointing register file: write ports, read ports,
// checkpoint control and status. Signal names carry the direction seen by the RF.
interface segre_rf_ckpt_if #(
    parameter int NUM_REGS   = 32,
    parameter int WORD_W     = 32,
    parameter int NUM_WPORTS = 3,
    parameter int NUM_RPORTS = 3,
    parameter int HIST_DEPTH = 16
) ();
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(HIST_DEPTH + 1);

    logic [NUM_WPORTS-1:0]             we_i;
    logic [NUM_WPORTS-1:0][AW-1:0]     waddr_i;
    logic [NUM_WPORTS-1:0][WORD_W-1:0] wdata_i;
    logic [NUM_RPORTS-1:0][AW-1:0]     raddr_i;
    logic [NUM_RPORTS-1:0][WORD_W-1:0] rdata_o;
    logic                              checkpoint_i;
    logic                              commit_i;
    logic                              rollback_i;
    logic                              ckpt_valid_o;
    logic                              busy_o;
    logic                              rb_done_o;
    logic                              ovf_o;
    logic [CW-1:0]                     hist_count_o;

    // No handshake: write and control inputs are sampled every cycle; busy_o
    // high means every write and control input presented that cycle is dropped.
    modport master (
        output we_i, waddr_i, wdata_i, raddr_i, checkpoint_i, commit_i, rollback_i,
        input  rdata_o, ckpt_valid_o, busy_o, rb_done_o, ovf_o, hist_count_o
    );

    modport slave (
        input  we_i, waddr_i, wdata_i, raddr_i, checkpoint_i, commit_i, rollback_i,
        output rdata_o, ckpt_valid_o, busy_o, rb_done_o, ovf_o, hist_count_o
    );
endinterface

// File: rtl/segre_rf_ckpt.sv
// Multi-port integer register file with a LIFO undo history: writes after a
// checkpoint log old values, and rollback unwinds one entry per cycle.
module segre_rf_ckpt #(
    parameter int NUM_REGS   = 32,
    parameter int WORD_W     = 32,
    parameter int NUM_WPORTS = 3,
    parameter int NUM_RPORTS = 3,
    parameter int HIST_DEPTH = 16
) (
    input logic            clk_i,
    input logic            rsn_i,
    segre_rf_ckpt_if.slave rf_bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int CW = $clog2(HIST_DEPTH + 1);
    localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    typedef enum logic {IDLE, UNDO} state_e;

    state_e                              state_q;
    logic [NUM_REGS-1:0][WORD_W-1:0]     regs_q;
    logic [HIST_DEPTH-1:0][AW-1:0]       hist_addr_q;
    logic [HIST_DEPTH-1:0][WORD_W-1:0]   hist_data_q;
    logic [CW-1:0]                       cnt_q;
    logic                                ckpt_q;
    logic                                rb_done_q;
    logic                                ovf_q;

    logic                                idle;
    logic                                rb_acc;
    logic                                log_en;
    logic                                ovf_d;
    logic [NUM_WPORTS-1:0]               eff;
    logic [NUM_WPORTS-1:0][HW-1:0]       push_pos;
    logic [HW-1:0]                       top_idx;
    int                                  n_eff;

    // Effective-write mask plus the history slot each logged write lands in;
    // lower ports push first so they sit deeper in the stack.
    always_comb begin
        idle     = (state_q == IDLE);
        rb_acc   = idle && rf_bus.rollback_i && ckpt_q;
        log_en   = idle && ckpt_q && !rb_acc && !rf_bus.checkpoint_i && !rf_bus.commit_i;
        eff      = '0;
        push_pos = '0;
        n_eff    = 0;
        for (int k = 0; k < NUM_WPORTS; k++) begin
            eff[k] = rf_bus.we_i[k] && (rf_bus.waddr_i[k] != '0) && idle && !rb_acc;
            for (int j = 0; j < k; j++) begin
                if (rf_bus.we_i[j] && (rf_bus.waddr_i[j] == rf_bus.waddr_i[k])) eff[k] = 1'b0;
            end
            push_pos[k] = HW'(int'(cnt_q) + n_eff);
            if (eff[k]) n_eff = n_eff + 1;
        end
        ovf_d   = log_en && ((int'(cnt_q) + n_eff) > HIST_DEPTH);
        top_idx = HW'(cnt_q - CW'(1));
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q     <= IDLE;
            regs_q      <= '0;
            hist_addr_q <= '0;
            hist_data_q <= '0;
            cnt_q       <= '0;
            ckpt_q      <= 1'b0;
            rb_done_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            rb_done_q <= 1'b0;
            ovf_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    for (int k = 0; k < NUM_WPORTS; k++) begin
                        if (eff[k]) regs_q[rf_bus.waddr_i[k]] <= rf_bus.wdata_i[k];
                    end
                    if (rb_acc) begin
                        if (cnt_q != '0) state_q   <= UNDO;
                        else             rb_done_q <= 1'b1;
                    end else if (rf_bus.checkpoint_i) begin
                        cnt_q  <= '0;
                        ckpt_q <= 1'b1;
                    end else if (rf_bus.commit_i) begin
                        cnt_q  <= '0;
                        ckpt_q <= 1'b0;
                    end else if (log_en) begin
                        if (ovf_d) begin
                            // The checkpoint can no longer be honoured, so drop it.
                            cnt_q  <= '0;
                            ckpt_q <= 1'b0;
                            ovf_q  <= 1'b1;
                        end else begin
                            for (int k = 0; k < NUM_WPORTS; k++) begin
                                if (eff[k]) begin
                                    hist_addr_q[push_pos[k]] <= rf_bus.waddr_i[k];
                                    hist_data_q[push_pos[k]] <= regs_q[rf_bus.waddr_i[k]];
                                end
                            end
                            cnt_q <= cnt_q + CW'(n_eff);
                        end
                    end
                end
                UNDO: begin
                    regs_q[hist_addr_q[top_idx]] <= hist_data_q[top_idx];
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q   <= IDLE;
                        rb_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rf_bus.rdata_o[p] = (rf_bus.raddr_i[p] == '0) ? '0 : regs_q[rf_bus.raddr_i[p]];
        end
    end

    assign rf_bus.ckpt_valid_o = ckpt_q;
    assign rf_bus.busy_o       = (state_q == UNDO);
    assign rf_bus.rb_done_o    = rb_done_q;
    assign rf_bus.ovf_o        = ovf_q;
    assign rf_bus.hist_count_o = cnt_q;
endmodule

// File: tb/tb_segre_rf_ckpt.sv
// Directed bench for segre_rf_ckpt: writes, checkpoint/commit/rollback,
// overflow boundaries, async reset during rollback and register 0.
module tb_segre_rf_ckpt;
    localparam int NUM_REGS   = 32;
    localparam int WORD_W     = 32;
    localparam int NUM_WPORTS = 3;
    localparam int NUM_RPORTS = 3;
    localparam int HIST_DEPTH = 16;

    logic clk_i = 1'b0;
    logic rsn_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    segre_rf_ckpt_if #(
        .NUM_REGS(NUM_REGS), .WORD_W(WORD_W), .NUM_WPORTS(NUM_WPORTS),
        .NUM_RPORTS(NUM_RPORTS), .HIST_DEPTH(HIST_DEPTH)
    ) rf_bus ();

    segre_rf_ckpt #(
        .NUM_REGS(NUM_REGS), .WORD_W(WORD_W), .NUM_WPORTS(NUM_WPORTS),
        .NUM_RPORTS(NUM_RPORTS), .HIST_DEPTH(HIST_DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rsn_i  (rsn_i),
        .rf_bus (rf_bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        rf_bus.we_i         = '0;
        rf_bus.waddr_i      = '0;
        rf_bus.wdata_i      = '0;
        rf_bus.checkpoint_i = 1'b0;
        rf_bus.commit_i     = 1'b0;
        rf_bus.rollback_i   = 1'b0;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
        rf_bus.we_i[p]    = 1'b1;
        rf_bus.waddr_i[p] = a;
        rf_bus.wdata_i[p] = d;
    endtask

    // Active edge, settle, then withdraw all write/control inputs.
    task automatic tick();
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic rd(input string tag, input int p, input logic [4:0] a, input logic [31:0] exp);
        rf_bus.raddr_i[p] = a;
        #1;
        check(tag, rf_bus.rdata_o[p], exp);
    endtask

    initial begin
        clear_inputs();
        rf_bus.raddr_i = '0;
        rsn_i = 1'b0;
        #2;
        check("rst_ckpt_valid", rf_bus.ckpt_valid_o, 0);
        check("rst_busy", rf_bus.busy_o, 0);
        check("rst_rb_done", rf_bus.rb_done_o, 0);
        check("rst_ovf", rf_bus.ovf_o, 0);
        check("rst_count", rf_bus.hist_count_o, 0);
        #10 rsn_i = 1'b1;

        // Basic ports
        wr(0, 5, 32'hAAAA_0001);
        wr(1, 6, 32'h0000_1234);
        tick();
        rf_bus.raddr_i[0] = 5;
        rf_bus.raddr_i[1] = 6;
        rf_bus.raddr_i[2] = 0;
        #1;
        check("rd_x5", rf_bus.rdata_o[0], 32'hAAAA_0001);
        check("rd_x6", rf_bus.rdata_o[1], 32'h0000_1234);
        check("rd_x0", rf_bus.rdata_o[2], 0);
        wr(0, 7, 32'h111);
        wr(2, 7, 32'h222);
        tick();
        rd("port_prio_x7", 1, 7, 32'h111);

        // Rollback of a multi-entry history
        wr(0, 3, 32'h10);
        tick();
        rf_bus.checkpoint_i = 1'b1;
        tick();
        check("ckpt_open", rf_bus.ckpt_valid_o, 1);
        check("ckpt_count0", rf_bus.hist_count_o, 0);
        wr(0, 3, 32'h20);
        wr(1, 4, 32'h30);
        tick();
        check("count_2", rf_bus.hist_count_o, 2);
        wr(0, 3, 32'h40);
        tick();
        check("count_3", rf_bus.hist_count_o, 3);
        rf_bus.rollback_i = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("undo_busy_%0d", i), rf_bus.busy_o, 1);
            check($sformatf("undo_nodone_%0d", i), rf_bus.rb_done_o, 0);
            tick();
        end
        check("rb_busy_low", rf_bus.busy_o, 0);
        check("rb_done_pulse", rf_bus.rb_done_o, 1);
        check("rb_count0", rf_bus.hist_count_o, 0);
        check("rb_ckpt_kept", rf_bus.ckpt_valid_o, 1);
        rd("rb_x3", 0, 3, 32'h10);
        rd("rb_x4", 0, 4, 32'h0);
        tick();
        check("rb_done_cleared", rf_bus.rb_done_o, 0);

        // Commit discards the checkpoint
        rf_bus.checkpoint_i = 1'b1;
        tick();
        wr(0, 8, 32'h99);
        tick();
        check("commit_pre_count", rf_bus.hist_count_o, 1);
        rf_bus.commit_i = 1'b1;
        tick();
        check("commit_count", rf_bus.hist_count_o, 0);
        check("commit_ckpt", rf_bus.ckpt_valid_o, 0);
        rf_bus.rollback_i = 1'b1;
        tick();
        check("norb_busy", rf_bus.busy_o, 0);
        check("norb_done", rf_bus.rb_done_o, 0);
        rd("norb_x8", 0, 8, 32'h99);

        // Overflow: 15 logged then two more
        rf_bus.checkpoint_i = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            wr(0, 5'(10 + i), 32'h100 + i);
            tick();
        end
        check("ovf_pre_count", rf_bus.hist_count_o, 15);
        wr(0, 25, 32'hA5A5);
        wr(1, 26, 32'h5A5A);
        tick();
        check("ovf_pulse", rf_bus.ovf_o, 1);
        check("ovf_ckpt", rf_bus.ckpt_valid_o, 0);
        check("ovf_count", rf_bus.hist_count_o, 0);
        rd("ovf_x25", 0, 25, 32'hA5A5);
        rd("ovf_x26", 1, 26, 32'h5A5A);
        tick();
        check("ovf_pulse_end", rf_bus.ovf_o, 0);

        // Exactly full history is not an overflow
        rf_bus.checkpoint_i = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            wr(0, 5'(10 + i), 32'h200 + i);
            tick();
        end
        wr(0, 24, 32'h1);
        wr(1, 25, 32'h2);
        tick();
        check("full_no_ovf", rf_bus.ovf_o, 0);
        check("full_count", rf_bus.hist_count_o, 16);
        check("full_ckpt", rf_bus.ckpt_valid_o, 1);
        rf_bus.checkpoint_i = 1'b1;
        tick();

        // Rollback wins over checkpoint; writes during it are dropped
        wr(0, 29, 32'h5);
        tick();
        wr(0, 29, 32'h6);
        tick();
        check("ia_count", rf_bus.hist_count_o, 2);
        rf_bus.rollback_i   = 1'b1;
        rf_bus.checkpoint_i = 1'b1;
        wr(0, 30, 32'h77);
        tick();
        check("rb_beats_ckpt", rf_bus.busy_o, 1);
        wr(0, 31, 32'h88);
        tick();
        check("ia_busy2", rf_bus.busy_o, 1);
        rd("ia_mid_x29", 2, 29, 32'h5);
        wr(1, 28, 32'h99);
        tick();
        check("ia_done", rf_bus.rb_done_o, 1);
        rd("ia_x29", 0, 29, 32'h0);
        rd("ia_x30_dropped", 1, 30, 32'h0);
        rd("ia_x31_dropped", 2, 31, 32'h0);
        rd("ia_x28_dropped", 0, 28, 32'h0);

        // Asynchronous reset in the middle of a 5-entry rollback
        for (int i = 1; i <= 5; i++) begin
            wr(0, 5'(i), 32'h11 * i);
            tick();
        end
        check("rst_pre_count", rf_bus.hist_count_o, 5);
        rf_bus.rollback_i = 1'b1;
        tick();
        tick();
        check("rst_mid_busy", rf_bus.busy_o, 1);
        #1 rsn_i = 1'b0;
        #1;
        check("arst_busy", rf_bus.busy_o, 0);
        check("arst_count", rf_bus.hist_count_o, 0);
        check("arst_ckpt", rf_bus.ckpt_valid_o, 0);
        rd("arst_x5", 0, 5, 32'h0);
        rd("arst_x8", 1, 8, 32'h0);
        @(negedge clk_i);
        rsn_i = 1'b1;

        // Register 0 writes are dropped and never logged
        rf_bus.checkpoint_i = 1'b1;
        tick();
        wr(0, 0, 32'hFFFF);
        tick();
        check("x0_count", rf_bus.hist_count_o, 0);
        rd("x0_read", 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
